up_bus_arbiter: RTL and testbench

- Shares the single up_* register bus (cs/wr/rd/addr/data) between two masters: m0 is the external host CPU port and m1 is the internal test sequencer.
- Each master issues one transaction at a time through a req/ack handshake.
- The arbiter grants masters round-robin and generates the one-cycle up_cs strobe protocol used by the register slaves.
- For reads, it waits a fixed latency, captures up_data_rd and returns it with the ack.

---
 rtl/up_bus_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_up_bus_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/up_bus_arbiter.sv
// up_bus_arbiter
//   Shares one up_* register bus between two masters (m0 = host CPU port,
//   m1 = internal test sequencer). Masters are granted round-robin. Each
//   transaction produces a single-cycle up_cs strobe. Reads wait RD_LAT
//   cycles, capture up_data_rd and return it together with the ack. After
//   every ack the bus is held idle for GAP cycles.
//
// Parameters
//   RD_LAT  cycles after the strobe cycle until up_data_rd is valid (1..15)
//   GAP     idle cycles forced after each ack (0..15)
//
// Ports
//   up_clk, up_rst_n         clock, synchronous active-low reset
//   mN_req/wr/addr/wdata     master N request and fields, held until mN_ack
//   mN_ack                   one-cycle completion pulse
//   mN_rdata                 read data, valid with mN_ack on reads; holds
//   up_cs/wr/rd/addr/data_wr bus strobe, qualifiers, address, write data
//   up_data_rd               slave read data
//   grant                    master owning the current transaction
//   busy                     high whenever the FSM is not IDLE
module up_bus_arbiter #(
  parameter int RD_LAT = 2,
  parameter int GAP    = 1
) (
  input  logic        up_clk,
  input  logic        up_rst_n,
  input  logic        m0_req,
  input  logic        m0_wr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_wr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
  output logic        up_cs,
  output logic        up_wr,
  output logic        up_rd,
  output logic [31:0] up_addr,
  output logic [31:0] up_data_wr,
  input  logic [31:0] up_data_rd,
  output logic        grant,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STROBE,
    S_WAIT,
    S_ACK,
    S_GAP
  } state_t;

  // Terminal counts for the 4-bit WAIT/GAP counter. GAP_LAST is only used
  // when GAP > 0.
  localparam logic [3:0] RD_LAST  = 4'(RD_LAT - 1);
  localparam logic [3:0] GAP_LAST = 4'(GAP - 1);

  state_t      state_reg;
  logic [3:0]  cnt_reg;
  logic        ptr_reg;     // preferred master when both request
  logic        lat_wr_reg;  // direction of the transaction in flight
  logic [1:0]  ack_reg;
  logic [31:0] rdata_reg [2];

  logic [1:0]  req;
  logic [1:0]  wr_sel;
  logic [31:0] addr_sel  [2];
  logic [31:0] wdata_sel [2];
  logic        pick;

  assign req          = {m1_req, m0_req};
  assign wr_sel       = {m1_wr, m0_wr};
  assign addr_sel[0]  = m0_addr;
  assign addr_sel[1]  = m1_addr;
  assign wdata_sel[0] = m0_wdata;
  assign wdata_sel[1] = m1_wdata;

  // Contention goes to the pointer; otherwise to whichever master requests.
  assign pick = (req == 2'b11) ? ptr_reg : req[1];

  assign m0_ack   = ack_reg[0];
  assign m1_ack   = ack_reg[1];
  assign m0_rdata = rdata_reg[0];
  assign m1_rdata = rdata_reg[1];

  always_ff @(posedge up_clk) begin
    if (!up_rst_n) begin
      state_reg    <= S_IDLE;
      cnt_reg      <= '0;
      ptr_reg      <= 1'b0;
      lat_wr_reg   <= 1'b0;
      ack_reg      <= '0;
      rdata_reg[0] <= '0;
      rdata_reg[1] <= '0;
      up_cs        <= 1'b0;
      up_wr        <= 1'b0;
      up_rd        <= 1'b0;
      up_addr      <= '0;
      up_data_wr   <= '0;
      grant        <= 1'b0;
      busy         <= 1'b0;
    end else begin
      // Bus fields and acks are single-cycle pulses; default them low.
      up_cs      <= 1'b0;
      up_wr      <= 1'b0;
      up_rd      <= 1'b0;
      up_addr    <= '0;
      up_data_wr <= '0;
      ack_reg    <= '0;

      case (state_reg)
        S_IDLE: begin
          if (|req) begin
            grant      <= pick;
            ptr_reg    <= ~pick;
            lat_wr_reg <= wr_sel[pick];
            // The strobe is registered here so it is visible exactly in
            // the STROBE cycle.
            up_cs      <= 1'b1;
            up_addr    <= addr_sel[pick];
            up_wr      <= wr_sel[pick];
            up_rd      <= ~wr_sel[pick];
            up_data_wr <= wr_sel[pick] ? wdata_sel[pick] : 32'h0;
            busy       <= 1'b1;
            state_reg  <= S_STROBE;
          end
        end

        S_STROBE: begin
          cnt_reg <= '0;
          if (lat_wr_reg) begin
            ack_reg[grant] <= 1'b1;
            state_reg      <= S_ACK;
          end else begin
            state_reg <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (cnt_reg == RD_LAST) begin
            rdata_reg[grant] <= up_data_rd;
            ack_reg[grant]   <= 1'b1;
            state_reg        <= S_ACK;
          end else begin
            cnt_reg <= cnt_reg + 4'd1;
          end
        end

        S_ACK: begin
          cnt_reg <= '0;
          if (GAP > 0) begin
            state_reg <= S_GAP;
          end else begin
            busy      <= 1'b0;
            state_reg <= S_IDLE;
          end
        end

        S_GAP: begin
          if (cnt_reg == GAP_LAST) begin
            busy      <= 1'b0;
            state_reg <= S_IDLE;
          end else begin
            cnt_reg <= cnt_reg + 4'd1;
          end
        end

        default: begin
          busy      <= 1'b0;
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_up_bus_arbiter.sv
// Bench for up_bus_arbiter. Instance 0 uses RD_LAT=2/GAP=1, instance 1 uses
// RD_LAT=1/GAP=0. Stimulus pushes expected strobes and acks (with the cycle
// they must appear in) into per-instance queues; the monitor pops them
// whenever the DUT shows a strobe or an ack.
module tb_up_bus_arbiter;

  typedef struct {
    bit          m;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } ev_t;

  logic        clk;
  logic        rst_n;
  logic        req      [2][2];
  logic        wr_in    [2][2];
  logic [31:0] addr_in  [2][2];
  logic [31:0] wdata_in [2][2];
  logic        ack      [2][2];
  logic [31:0] rdata    [2][2];
  logic        up_cs      [2];
  logic        up_wr      [2];
  logic        up_rd      [2];
  logic [31:0] up_addr    [2];
  logic [31:0] up_data_wr [2];
  logic [31:0] up_data_rd [2];
  logic        grant      [2];
  logic        busy       [2];

  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  int          due [2];
  logic [31:0] slave_val [2];
  logic [31:0] exp_rd [2][2];
  ev_t         sq [2][$];
  ev_t         aq [2][$];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      up_bus_arbiter #(
        .RD_LAT((gi == 0) ? 2 : 1),
        .GAP   ((gi == 0) ? 1 : 0)
      ) dut (
        .up_clk    (clk),
        .up_rst_n  (rst_n),
        .m0_req    (req[gi][0]),
        .m0_wr     (wr_in[gi][0]),
        .m0_addr   (addr_in[gi][0]),
        .m0_wdata  (wdata_in[gi][0]),
        .m0_ack    (ack[gi][0]),
        .m0_rdata  (rdata[gi][0]),
        .m1_req    (req[gi][1]),
        .m1_wr     (wr_in[gi][1]),
        .m1_addr   (addr_in[gi][1]),
        .m1_wdata  (wdata_in[gi][1]),
        .m1_ack    (ack[gi][1]),
        .m1_rdata  (rdata[gi][1]),
        .up_cs     (up_cs[gi]),
        .up_wr     (up_wr[gi]),
        .up_rd     (up_rd[gi]),
        .up_addr   (up_addr[gi]),
        .up_data_wr(up_data_wr[gi]),
        .up_data_rd(up_data_rd[gi]),
        .grant     (grant[gi]),
        .busy      (busy[gi])
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int rl(int i);
    return (i == 0) ? 2 : 1;
  endfunction

  // Slave: read data is correct only in the cycle RD_LAT after the strobe.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 2; i++)
      up_data_rd[i] = (cyc == due[i]) ? slave_val[i] : (32'hBAD0_0000 ^ 32'(cyc));
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (up_cs[i]) begin
        if (up_rd[i]) due[i] = cyc + rl(i);
        checks++;
        if (sq[i].size() == 0) begin
          failures++;
          $display("FAIL strobe_unexpected inst%0d cyc=%0d addr=%h grant=%0d", i, cyc, up_addr[i], grant[i]);
        end else begin
          ev_t e;
          e = sq[i].pop_front();
          if (cyc != e.cyc || grant[i] != e.m || up_wr[i] != e.wr || up_rd[i] != !e.wr ||
              up_addr[i] != e.addr || up_data_wr[i] != (e.wr ? e.data : 32'h0) || !busy[i]) begin
            failures++;
            $display("FAIL strobe inst%0d got cyc=%0d g=%0d wr=%0d rd=%0d a=%h d=%h busy=%0d need cyc=%0d g=%0d wr=%0d a=%h d=%h",
                     i, cyc, grant[i], up_wr[i], up_rd[i], up_addr[i], up_data_wr[i], busy[i],
                     e.cyc, e.m, e.wr, e.addr, e.wr ? e.data : 32'h0);
          end else begin
            $display("strobe inst%0d cyc=%0d m%0d %s a=%h d=%h ok", i, cyc, e.m, e.wr ? "WR" : "RD", e.addr, up_data_wr[i]);
          end
        end
      end else if (up_wr[i] || up_rd[i] || up_addr[i] != 32'h0 || up_data_wr[i] != 32'h0) begin
        failures++;
        $display("FAIL bus_idle inst%0d cyc=%0d got wr=%0d rd=%0d a=%h d=%h need all 0",
                 i, cyc, up_wr[i], up_rd[i], up_addr[i], up_data_wr[i]);
      end

      for (int m = 0; m < 2; m++) begin
        if (ack[i][m]) begin
          checks++;
          if (aq[i].size() == 0) begin
            failures++;
            $display("FAIL ack_unexpected inst%0d m%0d cyc=%0d", i, m, cyc);
          end else begin
            ev_t e;
            e = aq[i].pop_front();
            if (!e.wr) exp_rd[i][e.m] = e.data;
            if (cyc != e.cyc || e.m != 1'(m) || grant[i] != 1'(m) ||
                rdata[i][0] != exp_rd[i][0] || rdata[i][1] != exp_rd[i][1]) begin
              failures++;
              $display("FAIL ack inst%0d got m%0d cyc=%0d g=%0d rd0=%h rd1=%h need m%0d cyc=%0d rd0=%h rd1=%h",
                       i, m, cyc, grant[i], rdata[i][0], rdata[i][1], e.m, e.cyc, exp_rd[i][0], exp_rd[i][1]);
            end else begin
              $display("ack    inst%0d cyc=%0d m%0d %s rd0=%h rd1=%h ok", i, cyc, m, e.wr ? "WR" : "RD", rdata[i][0], rdata[i][1]);
            end
          end
        end
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  function automatic bit all_zero(int i);
    return !up_cs[i] && !up_wr[i] && !up_rd[i] && up_addr[i] == 32'h0 && up_data_wr[i] == 32'h0 &&
           !grant[i] && !busy[i] && !ack[i][0] && !ack[i][1] && rdata[i][0] == 32'h0 && rdata[i][1] == 32'h0;
  endfunction

  task automatic check_reset(int i, string name);
    checks++;
    if (!all_zero(i)) begin
      failures++;
      $display("FAIL %s inst%0d got cs=%0d wr=%0d rd=%0d a=%h g=%0d busy=%0d ack=%0d%0d rd0=%h rd1=%h need all 0",
               name, i, up_cs[i], up_wr[i], up_rd[i], up_addr[i], grant[i], busy[i],
               ack[i][1], ack[i][0], rdata[i][0], rdata[i][1]);
    end else begin
      $display("%s inst%0d outputs all 0 ok", name, i);
    end
  endtask

  // e = clock edge at which the request is sampled in IDLE.
  task automatic expect_txn(int i, bit m, bit w, logic [31:0] a, logic [31:0] d, int e);
    ev_t s;
    s.m = m; s.wr = w; s.addr = a; s.data = d; s.cyc = e;
    sq[i].push_back(s);
    s.cyc = w ? e + 1 : e + 1 + rl(i);
    aq[i].push_back(s);
  endtask

  // Master: raise req, hold until ack, drop req in the following cycle.
  task automatic drive(int i, int m, bit w, logic [31:0] a, logic [31:0] d);
    int n;
    req[i][m] = 1'b1; wr_in[i][m] = w; addr_in[i][m] = a; wdata_in[i][m] = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack[i][m] && n < 300);
    if (!ack[i][m]) begin
      checks++;
      failures++;
      $display("FAIL ack_timeout inst%0d m%0d got no ack need ack within 300 cycles", i, m);
    end
    @(posedge clk);
    #1;
    req[i][m] = 1'b0;
  endtask

  initial begin
    int e;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      due[i] = -100;
      slave_val[i] = 32'h0;
      for (int m = 0; m < 2; m++) begin
        req[i][m] = 1'b0; wr_in[i][m] = 1'b0; addr_in[i][m] = 32'h0; wdata_in[i][m] = 32'h0;
        exp_rd[i][m] = 32'h0;
      end
    end
    repeat (3) sync();
    check_reset(0, "reset");
    check_reset(1, "reset");
    rst_n = 1'b1;
    sync();

    // m0 write.
    e = cyc + 1;
    expect_txn(0, 1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, e);
    drive(0, 0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    repeat (3) sync();

    // m1 read; write-data field is junk and must not reach the bus.
    slave_val[0] = 32'h1234_5678;
    e = cyc + 1;
    expect_txn(0, 1'b1, 1'b0, 32'h0000_0020, 32'h1234_5678, e);
    drive(0, 1, 1'b0, 32'h0000_0020, 32'hFFFF_0000);
    repeat (3) sync();

    // Both masters request together, twice each: m0, m1, m0, m1.
    e = cyc + 1;
    expect_txn(0, 1'b0, 1'b1, 32'h0000_0100, 32'hA000_0000, e);
    expect_txn(0, 1'b1, 1'b1, 32'h0000_0104, 32'hA000_0001, e + 4);
    expect_txn(0, 1'b0, 1'b1, 32'h0000_0108, 32'hA000_0002, e + 8);
    expect_txn(0, 1'b1, 1'b1, 32'h0000_010C, 32'hA000_0003, e + 12);
    fork
      begin
        drive(0, 0, 1'b1, 32'h0000_0100, 32'hA000_0000);
        sync();
        drive(0, 0, 1'b1, 32'h0000_0108, 32'hA000_0002);
      end
      begin
        drive(0, 1, 1'b1, 32'h0000_0104, 32'hA000_0001);
        sync();
        drive(0, 1, 1'b1, 32'h0000_010C, 32'hA000_0003);
      end
    join
    repeat (3) sync();

    // Reset while an m1 read sits in WAIT: no ack may ever appear.
    slave_val[0] = 32'h5555_AAAA;
    e = cyc + 1;
    sq[0].push_back('{m: 1'b1, wr: 1'b0, addr: 32'h0000_0030, data: 32'h0, cyc: e});
    req[0][1] = 1'b1; wr_in[0][1] = 1'b0; addr_in[0][1] = 32'h0000_0030; wdata_in[0][1] = 32'h0;
    sync();
    sync();
    rst_n = 1'b0;
    sync();
    check_reset(0, "reset_in_wait");
    req[0][1] = 1'b0;
    sync();
    rst_n = 1'b1;
    exp_rd[0][0] = 32'h0;
    exp_rd[0][1] = 32'h0;
    sync();

    slave_val[0] = 32'h600D_F00D;
    e = cyc + 1;
    expect_txn(0, 1'b1, 1'b0, 32'h0000_0034, 32'h600D_F00D, e);
    drive(0, 1, 1'b0, 32'h0000_0034, 32'h0);
    repeat (3) sync();

    e = cyc + 1;
    expect_txn(0, 1'b0, 1'b1, 32'h0000_0038, 32'hB000_0000, e);
    expect_txn(0, 1'b1, 1'b1, 32'h0000_003C, 32'hB000_0001, e + 4);
    fork
      drive(0, 0, 1'b1, 32'h0000_0038, 32'hB000_0000);
      drive(0, 1, 1'b1, 32'h0000_003C, 32'hB000_0001);
    join
    repeat (3) sync();

    // m0 requests only while m1 owns the bus and gives up before IDLE.
    slave_val[0] = 32'h89AB_CDEF;
    e = cyc + 1;
    expect_txn(0, 1'b1, 1'b0, 32'h0000_0040, 32'h89AB_CDEF, e);
    fork
      drive(0, 1, 1'b0, 32'h0000_0040, 32'h0);
      begin
        sync();
        req[0][0] = 1'b1; wr_in[0][0] = 1'b1; addr_in[0][0] = 32'h0000_0DEA; wdata_in[0][0] = 32'h0BAD_0BAD;
        sync();
        sync();
        req[0][0] = 1'b0;
      end
    join
    repeat (4) sync();
    e = cyc + 1;
    expect_txn(0, 1'b0, 1'b1, 32'h0000_0044, 32'hC000_0000, e);
    drive(0, 0, 1'b1, 32'h0000_0044, 32'hC000_0000);
    repeat (3) sync();

    // Instance 1 (RD_LAT=1, GAP=0): m0 read then m0 write.
    slave_val[1] = 32'h7777_1111;
    e = cyc + 1;
    expect_txn(1, 1'b0, 1'b0, 32'h0000_0050, 32'h7777_1111, e);
    expect_txn(1, 1'b0, 1'b1, 32'h0000_0054, 32'hA5A5_A5A5, e + 5);
    drive(1, 0, 1'b0, 32'h0000_0050, 32'h0);
    sync();
    drive(1, 0, 1'b1, 32'h0000_0054, 32'hA5A5_A5A5);
    repeat (5) sync();

    for (int i = 0; i < 2; i++) begin
      checks++;
      if (sq[i].size() != 0 || aq[i].size() != 0 || busy[i]) begin
        failures++;
        $display("FAIL drain inst%0d got strobes_left=%0d acks_left=%0d busy=%0d need 0 0 0",
                 i, sq[i].size(), aq[i].size(), busy[i]);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
